// File: rtl/uart_pkg.sv
// Shared UART timebase definitions: default field widths, word types,
// oversampling ratio and the baud generator's activity FSM encoding.
package uart_pkg;

  localparam int DL_WIDTH_DEF  = 16;
  localparam int PSD_WIDTH_DEF = 4;
  localparam int OVERSAMPLE    = 16;

  typedef logic [DL_WIDTH_DEF-1:0]               dl_word_t;
  typedef logic [PSD_WIDTH_DEF-1:0]              psd_word_t;
  typedef logic [DL_WIDTH_DEF+PSD_WIDTH_DEF-1:0] cnt_t;

  // IDLE loads the divisor itself on the first edge out of reset; LOAD is the
  // one-cycle dead time that follows a new_baud request.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } baud_state_t;

endpackage

// File: rtl/baud_div_cnt.sv
// Terminal-count down-counter: loads i_reload, counts down while enabled and
// reloads itself when it strobes o_tc at zero, giving a period of i_reload+1.
module baud_div_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_reload,
  input  logic             i_en,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_cnt;

  assign o_tc = i_en && (r_cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_reload;
    end else if (i_en) begin
      r_cnt <= (r_cnt == '0) ? i_reload : r_cnt - WIDTH'(1);
    end
  end

endmodule

// File: rtl/baud_gen.sv
// Programmable 16550-style baud generator: clk / (DL*(psd+1)) gives the 16x
// sample_tick, and every 16th sample tick also raises baud_tick.
module baud_gen
  import uart_pkg::*;
#(
  parameter int DL_WIDTH  = DL_WIDTH_DEF,
  parameter int PSD_WIDTH = PSD_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DL_WIDTH-1:0]  divisor_latch,
  input  logic [PSD_WIDTH-1:0] psd,
  input  logic                 new_baud,
  input  logic                 enable_sample,
  input  logic                 enable_baud,
  output logic                 baud_tick,
  output logic                 sample_tick,
  output logic                 active,
  output baud_state_t          dbg_state
);

  localparam int SCW = $clog2(OVERSAMPLE);

  baud_state_t          r_state;
  baud_state_t          w_state_next;
  logic                 w_latch_en;
  logic [DL_WIDTH-1:0]  r_dl_l;
  logic [PSD_WIDTH-1:0] r_psd_l;
  logic [DL_WIDTH-1:0]  w_dl_next;
  logic [PSD_WIDTH-1:0] w_psd_next;
  logic [DL_WIDTH-1:0]  w_dl_reload;
  logic                 w_run;
  logic                 w_pre_tc;
  logic                 w_sample_strobe;
  logic                 w_baud_strobe;
  logic [SCW-1:0]       r_samp_cnt;
  logic                 r_sample_int;
  logic                 r_baud_int;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_latch_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_latch_en   = 1'b1;
        w_state_next = ST_RUN;
      end
      ST_LOAD: begin
        w_latch_en   = new_baud;
        w_state_next = new_baud ? ST_LOAD : ST_RUN;
      end
      ST_RUN: begin
        w_latch_en   = new_baud;
        w_state_next = new_baud ? ST_LOAD : ST_RUN;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dl_l  <= '0;
      r_psd_l <= '0;
    end else if (w_latch_en) begin
      r_dl_l  <= divisor_latch;
      r_psd_l <= psd;
    end
  end

  // Counters preload from the value being latched on the same edge, so a
  // restart never runs one period with stale settings.
  assign w_dl_next   = w_latch_en ? divisor_latch : r_dl_l;
  assign w_psd_next  = w_latch_en ? psd : r_psd_l;
  // DL of zero wraps to all-ones here, which is the 2**DL_WIDTH divide.
  assign w_dl_reload = w_dl_next - DL_WIDTH'(1);
  assign w_run       = (r_state == ST_RUN) && !new_baud;

  baud_div_cnt #(
    .WIDTH (PSD_WIDTH)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_latch_en),
    .i_reload (w_psd_next),
    .i_en     (w_run),
    .o_tc     (w_pre_tc)
  );

  baud_div_cnt #(
    .WIDTH (DL_WIDTH)
  ) u_dl_div (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_latch_en),
    .i_reload (w_dl_reload),
    .i_en     (w_pre_tc),
    .o_tc     (w_sample_strobe)
  );

  assign w_baud_strobe = w_sample_strobe && (r_samp_cnt == SCW'(OVERSAMPLE - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_samp_cnt   <= '0;
      r_sample_int <= 1'b0;
      r_baud_int   <= 1'b0;
    end else begin
      r_sample_int <= w_sample_strobe;
      r_baud_int   <= w_baud_strobe;
      if (w_latch_en) begin
        r_samp_cnt <= '0;
      end else if (w_sample_strobe) begin
        r_samp_cnt <= r_samp_cnt + SCW'(1);
      end
    end
  end

  assign sample_tick = r_sample_int & enable_sample;
  assign baud_tick   = r_baud_int & enable_baud;
  assign active      = (r_state == ST_RUN);
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_baud_gen.sv
// Bench for baud_gen: counts active clock edges after each (re)start and
// compares tick positions with the divide-ratio model N = DLeff*(psd+1).
module tb_baud_gen;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] divisor_latch = '0;
  logic [3:0]  psd = '0;
  logic        new_baud = 1'b0;
  logic        enable_sample = 1'b1;
  logic        enable_baud = 1'b1;
  logic        baud_tick;
  logic        sample_tick;
  logic        active;
  baud_state_t dbg_state;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int dl;
    int ps;
    bit es;
    bit eb;
    int n;      // expected sample period in active edges
    int limit;  // active edges to observe
  } vec_t;

  vec_t vecs[8];

  baud_gen u_dut (
    .clk           (clk),
    .reset         (reset),
    .divisor_latch (divisor_latch),
    .psd           (psd),
    .new_baud      (new_baud),
    .enable_sample (enable_sample),
    .enable_baud   (enable_baud),
    .baud_tick     (baud_tick),
    .sample_tick   (sample_tick),
    .active        (active),
    .dbg_state     (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic int model_period(input int dl, input int ps);
    return ((dl == 0) ? 65536 : dl) * (ps + 1);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_inputs(input int dl, input int ps, input bit es, input bit eb);
    divisor_latch = 16'(dl);
    psd           = 4'(ps);
    enable_sample = es;
    enable_baud   = eb;
  endtask

  // One-cycle new_baud: active must be low for exactly the cycle after it.
  task automatic pulse_new_baud(input string name, input int dl, input int ps,
                                input bit es, input bit eb);
    set_inputs(dl, ps, es, eb);
    new_baud = 1'b1;
    @(posedge clk); #1;
    new_baud = 1'b0;
    check({name, "_active_low"}, active, 0);
    @(posedge clk); #1;
    check({name, "_active_high"}, active, 1);
  endtask

  // Observe `limit` active edges and compare tick positions with the model.
  task automatic measure(input string name, input int n, input bit es, input bit eb,
                         input int limit);
    int   cnt = 0;
    int   cyc = 0;
    int   s1 = -1;
    int   s2 = -1;
    int   b1 = -1;
    int   scount = 0;
    int   bcount = 0;
    int   xs = 0;
    logic act_prev;
    while (cnt < limit && cyc < limit + 64) begin
      act_prev = active;
      @(posedge clk); #1;
      cyc++;
      if (act_prev === 1'b1) cnt++;
      if ($isunknown({active, sample_tick, baud_tick})) xs++;
      if (sample_tick === 1'b1) begin
        scount++;
        if (s1 < 0) s1 = cnt;
        else if (s2 < 0) s2 = cnt;
      end
      if (baud_tick === 1'b1) begin
        bcount++;
        if (b1 < 0) b1 = cnt;
      end
    end
    check({name, "_edges"}, cnt, limit);
    check({name, "_no_x"}, xs, 0);
    check({name, "_sample1"}, s1, (es && n <= limit) ? n : -1);
    check({name, "_sample2"}, s2, (es && 2 * n <= limit) ? 2 * n : -1);
    check({name, "_sample_cnt"}, scount, es ? limit / n : 0);
    check({name, "_baud1"}, b1, (eb && 16 * n <= limit) ? 16 * n : -1);
    check({name, "_baud_cnt"}, bcount, eb ? limit / (16 * n) : 0);
  endtask

  initial begin
    vecs[0] = '{dl: 651, ps: 0, es: 1, eb: 1, n: 651,  limit: 1302};
    vecs[1] = '{dl: 325, ps: 1, es: 1, eb: 1, n: 650,  limit: 1300};
    vecs[2] = '{dl: 325, ps: 0, es: 1, eb: 1, n: 325,  limit: 650};
    vecs[3] = '{dl: 108, ps: 0, es: 1, eb: 1, n: 108,  limit: 1728};
    vecs[4] = '{dl: 54,  ps: 0, es: 1, eb: 1, n: 54,   limit: 864};
    vecs[5] = '{dl: 54,  ps: 0, es: 0, eb: 1, n: 54,   limit: 864};
    vecs[6] = '{dl: 54,  ps: 1, es: 1, eb: 0, n: 108,  limit: 1728};
    vecs[7] = '{dl: 1,   ps: 0, es: 1, eb: 1, n: 1,    limit: 32};

    // Reset state with reference defaults on the inputs.
    set_inputs(0, 0, 1, 1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_active", active, 0);
    check("rst_sample", sample_tick, 0);
    check("rst_baud", baud_tick, 0);
    check("rst_state", dbg_state, ST_IDLE);

    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("start_active", active, 1);
    measure("default", model_period(0, 0), 1, 1, 65536);

    foreach (vecs[i]) begin
      pulse_new_baud($sformatf("vec%0d", i), vecs[i].dl, vecs[i].ps, vecs[i].es, vecs[i].eb);
      measure($sformatf("vec%0d", i), vecs[i].n, vecs[i].es, vecs[i].eb, vecs[i].limit);
    end

    for (int r = 0; r < 6; r++) begin
      int dl;
      int ps;
      int n;
      bit es;
      bit eb;
      dl = $urandom_range(1, 12);
      ps = $urandom_range(0, 3);
      es = 1'($urandom_range(0, 1));
      eb = 1'($urandom_range(0, 1));
      n  = model_period(dl, ps);
      pulse_new_baud($sformatf("rnd%0d", r), dl, ps, es, eb);
      measure($sformatf("rnd%0d", r), n, es, eb, 16 * n);
    end

    // Divisor changes without new_baud leave the running period alone.
    pulse_new_baud("chg", 20, 0, 1, 1);
    measure("pre_chg", 20, 1, 1, 40);
    set_inputs(3, 7, 1, 1);
    measure("post_chg", 20, 1, 1, 40);

    // new_baud held high keeps re-latching with active low.
    set_inputs(9, 0, 1, 1);
    new_baud = 1'b1;
    @(posedge clk); #1;
    check("hold_active0", active, 0);
    set_inputs(5, 1, 1, 1);
    @(posedge clk); #1;
    check("hold_active1", active, 0);
    new_baud = 1'b0;
    @(posedge clk); #1;
    check("hold_active2", active, 1);
    measure("hold", model_period(5, 1), 1, 1, 20);

    // Async reset lands while a sample tick is high.
    pulse_new_baud("pre_rst", 5, 0, 1, 1);
    measure("pre_rst", 5, 1, 1, 5);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_sample", sample_tick, 0);
    check("mid_rst_active", active, 0);
    check("mid_rst_baud", baud_tick, 0);
    check("mid_rst_state", dbg_state, ST_IDLE);
    set_inputs(4, 2, 1, 1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_active", active, 1);
    measure("post_rst", model_period(4, 2), 1, 1, 24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
